// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial pattern generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam int         PAT_W_DEF     = 4;
  localparam int         CNT_W_DEF     = 4;
  localparam int         GAP_W_DEF     = 3;
  localparam logic [3:0] PAT_DEFAULT_C = 4'b1011;

endpackage

// File: rtl/pattern_shifter.sv
// Parallel-load MSB-first shift register with a bit counter that flags the last bit.
module pattern_shifter #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] data,
  output logic             msb,
  output logic             last_bit
);

  localparam int            BW       = $clog2(PAT_W);
  localparam logic [BW-1:0] LAST_IDX = BW'(PAT_W - 1);

  logic [PAT_W-1:0] shift_reg, shift_next;
  logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;

  // Load has priority so a reload on the last bit restarts the pattern cleanly.
  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign shift_next[gi] = load ? data[gi] : (shift ? 1'b0 : shift_reg[gi]);
      end else begin : g_up
        assign shift_next[gi] = load ? data[gi] : (shift ? shift_reg[gi-1] : shift_reg[gi]);
      end
    end
  endgenerate

  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    if (load)
      bit_cnt_next = '0;
    else if (shift)
      bit_cnt_next = (bit_cnt_reg == LAST_IDX) ? '0 : bit_cnt_reg + BW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else begin
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  assign msb      = shift_reg[PAT_W-1];
  assign last_bit = (bit_cnt_reg == LAST_IDX);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: repeats a latched pattern MSB-first with optional gaps.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int               PAT_W       = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_DEFAULT_C,
  parameter int               CNT_W       = CNT_W_DEF,
  parameter int               GAP_W       = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_default,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [PAT_W-1:0] pat_lat_reg, pat_lat_next, pat_sel, load_data;
  logic [CNT_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic [GAP_W-1:0] gap_lat_reg, gap_lat_next, gap_cnt_reg, gap_cnt_next;
  logic             accept, rep_remain, pat_end, gap_end;
  logic             sh_load, sh_shift, sh_msb, sh_last;
  logic             x_next, x_valid_next, busy_next, done_next;

  assign accept     = (state_reg == IDLE) && start && !abort;
  assign rep_remain = (rep_cnt_reg > CNT_W'(1));
  assign pat_end    = (state_reg == SEND) && !abort && sh_last;
  assign gap_end    = (state_reg == GAP) && !abort && (gap_cnt_reg == '0);
  assign pat_sel    = use_default ? PAT_DEFAULT : pattern_in;

  // Reload from the latched copy: the shifter itself is consumed while sending.
  assign sh_load   = (accept && (repeat_n != '0))
                   || (pat_end && rep_remain && (gap_lat_reg == '0))
                   || gap_end;
  assign sh_shift  = (state_reg == SEND) && !abort;
  assign load_data = (state_reg == IDLE) ? pat_sel : pat_lat_reg;

  pattern_shifter #(.PAT_W(PAT_W)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_load),
    .shift    (sh_shift),
    .data     (load_data),
    .msb      (sh_msb),
    .last_bit (sh_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = (repeat_n != '0) ? SEND : DONE;
      SEND: begin
        if (abort)
          state_next = IDLE;
        else if (sh_last)
          state_next = !rep_remain ? DONE : ((gap_lat_reg != '0) ? GAP : SEND);
      end
      GAP: begin
        if (abort)                   state_next = IDLE;
        else if (gap_cnt_reg == '0)  state_next = SEND;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pat_lat_next = pat_lat_reg;
    rep_cnt_next = rep_cnt_reg;
    gap_lat_next = gap_lat_reg;
    gap_cnt_next = gap_cnt_reg;
    if (accept) begin
      pat_lat_next = pat_sel;
      rep_cnt_next = repeat_n;
      gap_lat_next = gap_len;
    end
    if (pat_end) begin
      rep_cnt_next = rep_cnt_reg - CNT_W'(1);
      if (rep_remain && (gap_lat_reg != '0))
        gap_cnt_next = gap_lat_reg - GAP_W'(1);
    end else if ((state_reg == GAP) && !abort && (gap_cnt_reg != '0)) begin
      gap_cnt_next = gap_cnt_reg - GAP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_lat_reg <= '0;
      rep_cnt_reg <= '0;
      gap_lat_reg <= '0;
      gap_cnt_reg <= '0;
    end else begin
      pat_lat_reg <= pat_lat_next;
      rep_cnt_reg <= rep_cnt_next;
      gap_lat_reg <= gap_lat_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  // Abort squashes outputs in the same cycle it is sampled, so no stray bit escapes.
  always_comb begin
    x_next       = 1'b0;
    x_valid_next = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      SEND: begin
        x_next       = sh_msb && !abort;
        x_valid_next = !abort;
        busy_next    = !abort;
      end
      GAP:     busy_next = !abort;
      DONE:    done_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      x       <= x_next;
      x_valid <= x_valid_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

endmodule
